color_pattern_gen: RTL and testbench

COLOR_PATTERN_GEN -- requirements
Module: color_pattern_gen

---
 rtl/color_gen_pkg.sv | 32 +++
 rtl/vga_timing_gen.sv | 66 ++++++
 rtl/color_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_color_pattern_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/color_gen_pkg.sv
// Shared definitions for the colour pattern generator.
// Contents: pattern mode enum, default 800x480 timing constants,
// and the colour-bar table with a lookup helper.
package color_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_EXT     = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Entry i is {r,g,b} full-scale flags of bar i, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational blank/sync decode of the current
// counter value. The parent registers the decode, giving 1-cycle latency.
// Ports: clk, rst_n (async low), en (advance enable),
//        pix_x/pix_y (current position), active, hsync_n, vsync_n,
//        origin (counters at (0,0)).
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           active,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           origin
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (x_q == X_W'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign pix_x   = x_q;
  assign pix_y   = y_q;
  assign active  = (x_q < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE));
  assign hsync_n = !((x_q >= X_W'(H_ACTIVE + H_FP)) &&
                     (x_q <  X_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_n = !((y_q >= Y_W'(V_ACTIVE + V_FP)) &&
                     (y_q <  Y_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign origin  = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/color_pattern_gen.sv
// VGA-style test pattern generator: SOLID (button-set levels), colour
// BARS, CHECKER, or EXTernal pixel passthrough. All video outputs are
// registered one cycle after the counter value they describe.
// Ports: clk, rst_n (async low), en, mode_sel, red/green/blue_btn
//        (async levels), ext_red/green/blue; outputs hsync_n, vsync_n,
//        blank_n, pix_x, pix_y, red, green, blue, frame_start.
module color_pattern_gen
  import color_gen_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int LEVEL_W  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode_sel,
  input  logic               red_btn,
  input  logic               green_btn,
  input  logic               blue_btn,
  input  logic [COLOR_W-1:0] ext_red,
  input  logic [COLOR_W-1:0] ext_green,
  input  logic [COLOR_W-1:0] ext_blue,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               blank_n,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start
);

  logic t_active, t_hsync_n, t_vsync_n, t_origin;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pix_x  (pix_x),
    .pix_y  (pix_y),
    .active (t_active),
    .hsync_n(t_hsync_n),
    .vsync_n(t_vsync_n),
    .origin (t_origin)
  );

  // Channel index 2=red, 1=green, 0=blue throughout.
  logic [2:0]                       btn_s1_q, btn_s1_d;
  logic [2:0]                       btn_s2_q, btn_s2_d;
  logic [2:0]                       btn_s3_q, btn_s3_d;
  logic [2:0][LEVEL_W-1:0]          lvl_q, lvl_d;
  mode_e                            mode_q, mode_d;
  logic [2:0][COLOR_W-1:0]          rgb_pix;
  logic [2:0][COLOR_W-1:0]          rgb_q, rgb_d;
  logic                             blank_q, blank_d;
  logic                             hs_q, hs_d;
  logic                             vs_q, vs_d;
  logic                             fs_q, fs_d;
  logic [2:0]                       bar_idx;
  logic [2:0]                       bar;

  // s1/s2 synchronise; s3 holds the previous synced value for edge detect.
  always_comb begin
    btn_s1_d = {red_btn, green_btn, blue_btn};
    btn_s2_d = btn_s1_q;
    btn_s3_d = btn_s2_q;
    lvl_d    = lvl_q;
    for (int c = 0; c < 3; c++) begin
      if (btn_s2_q[c] && !btn_s3_q[c]) lvl_d[c] = lvl_q[c] + 1'b1;
    end
  end

  // The new mode takes effect on pixel (0,0) itself, so a frame is
  // always rendered in a single mode.
  assign mode_d  = (en && t_origin) ? mode_e'(mode_sel) : mode_q;
  assign bar_idx = 3'(pix_x / X_W'(H_ACTIVE / 8));
  assign bar     = bar_rgb(bar_idx);

  always_comb begin
    rgb_pix = '0;
    case (mode_d)
      MODE_SOLID:
        for (int c = 0; c < 3; c++)
          rgb_pix[c] = {lvl_q[c], {(COLOR_W - LEVEL_W){1'b1}}};
      MODE_BARS:
        for (int c = 0; c < 3; c++)
          rgb_pix[c] = {COLOR_W{bar[c]}};
      MODE_CHECKER:
        rgb_pix = {(3 * COLOR_W){pix_x[5] ^ pix_y[5]}};
      default:
        rgb_pix = {ext_red, ext_green, ext_blue};
    endcase
  end

  always_comb begin
    blank_d = en && t_active;
    hs_d    = en ? t_hsync_n : 1'b1;
    vs_d    = en ? t_vsync_n : 1'b1;
    fs_d    = en && t_origin;
    rgb_d   = blank_d ? rgb_pix : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      btn_s3_q <= '0;
      lvl_q    <= '0;
      mode_q   <= MODE_SOLID;
      rgb_q    <= '0;
      blank_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      btn_s3_q <= btn_s3_d;
      lvl_q    <= lvl_d;
      mode_q   <= mode_d;
      rgb_q    <= rgb_d;
      blank_q  <= blank_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end

  assign red         = rgb_q[2];
  assign green       = rgb_q[1];
  assign blue        = rgb_q[0];
  assign blank_n     = blank_q;
  assign hsync_n     = hs_q;
  assign vsync_n     = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_color_pattern_gen.sv
// Randomized self-checking bench for color_pattern_gen, run with a
// shrunken raster (80x48 total) so several frames fit in a short run.
module tb_color_pattern_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int CW = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode_sel = 2'd0;
  logic          red_btn = 1'b0, green_btn = 1'b0, blue_btn = 1'b0;
  logic [CW-1:0] ext_red = '0, ext_green = '0, ext_blue = '0;
  logic          hsync_n, vsync_n, blank_n, frame_start;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] red, green, blue;

  always #5 clk = ~clk;

  color_pattern_gen #(
    .COLOR_W(CW), .LEVEL_W(LW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
    .red_btn(red_btn), .green_btn(green_btn), .blue_btn(blue_btn),
    .ext_red(ext_red), .ext_green(ext_green), .ext_blue(ext_blue),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n),
    .pix_x(pix_x), .pix_y(pix_y),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: next pixel to be drawn, latched mode, levels.
  int mx, my, mmode;
  int lvl[3];
  int cyc = 0;
  int last_fs = -1;
  logic e_blank, e_hs, e_vs, e_fs;
  int e_rgb[3];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pixel colour of channel c (2=r,1=g,0=b) at (x,y) in the latched mode.
  function automatic int pix_color(int c, int x, int y);
    int b;
    bit on;
    case (mmode)
      0: return (lvl[c] * (1 << (CW - LW))) + (1 << (CW - LW)) - 1;
      1: begin
        b = x / (HA / 8);
        // white yellow cyan green magenta red blue black
        if (c == 2)      on = (b == 0 || b == 1 || b == 4 || b == 5);
        else if (c == 1) on = (b < 4);
        else             on = (b % 2 == 0);
        return on ? 255 : 0;
      end
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 255 : 0;
      default: return (c == 2) ? int'(ext_red) : (c == 1) ? int'(ext_green)
                                                         : int'(ext_blue);
    endcase
  endfunction

  task automatic step();
    bit act;
    @(posedge clk);
    if (en) begin
      if (mx == 0 && my == 0) mmode = int'(mode_sel);
      act     = (mx < HA) && (my < VA);
      e_blank = act;
      e_hs    = !(mx >= HA + HF && mx < HA + HF + HS);
      e_vs    = !(my >= VA + VF && my < VA + VF + VS);
      e_fs    = (mx == 0 && my == 0);
      for (int c = 0; c < 3; c++) e_rgb[c] = act ? pix_color(c, mx, my) : 0;
      mx++;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end else begin
      e_blank = 0; e_hs = 1; e_vs = 1; e_fs = 0;
      for (int c = 0; c < 3; c++) e_rgb[c] = 0;
      last_fs = -1;
    end
    cyc++;
    @(negedge clk);
    check("video", 64'({blank_n, hsync_n, vsync_n, frame_start, red, green, blue}),
          64'({e_blank, e_hs, e_vs, e_fs, CW'(e_rgb[2]), CW'(e_rgb[1]), CW'(e_rgb[0])}));
    check("pos", 64'({pix_x, pix_y}), 64'({XW'(mx), YW'(my)}));
    if (frame_start) begin
      if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(HT * VT));
      last_fs = cyc;
    end
    ext_red   = CW'($urandom);
    ext_green = CW'($urandom);
    ext_blue  = CW'($urandom);
  endtask

  // Press and release buttons in mask {r,g,b}; long enough to settle.
  task automatic press(input logic [2:0] mask);
    {red_btn, green_btn, blue_btn} = mask;
    repeat (4) step();
    {red_btn, green_btn, blue_btn} = 3'b000;
    repeat (4) step();
    for (int c = 0; c < 3; c++) if (mask[c]) lvl[c] = (lvl[c] + 1) % (1 << LW);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({blank_n, hsync_n, vsync_n, frame_start, red, green, blue, pix_x, pix_y}),
          64'({1'b0, 1'b1, 1'b1, 1'b0, CW'(0), CW'(0), CW'(0), XW'(0), YW'(0)}));
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mmode = 0; last_fs = -1;
    for (int c = 0; c < 3; c++) lvl[c] = 0;
  endtask

  task automatic run_frames(input int n);
    repeat (n * HT * VT) step();
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    mode_sel = 2'd0;

    // Two full SOLID frames: timing, syncs and frame period.
    run_frames(2);

    // Three red presses -> red full scale; fourth wraps to 0x3F.
    en = 1'b0;
    repeat (3) press(3'b100);
    en = 1'b1;
    run_frames(1);
    en = 1'b0;
    press(3'b100);
    press(3'b011);
    press(3'b111);
    en = 1'b1;
    run_frames(1);

    // Mode change mid-frame must wait for the next frame start.
    for (int i = 0; i < HT * VT && my != 20; i++) step();
    mode_sel = 2'd2;
    run_frames(2);
    mode_sel = 2'd1;
    run_frames(2);
    mode_sel = 2'd3;
    run_frames(1);

    // Enable dropped at pixel (10,5) for 20 cycles.
    for (int i = 0; i < HT * VT && !(mx == 10 && my == 5); i++) step();
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    run_frames(1);

    // Random enable gaps, mode changes and button presses.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) mode_sel = 2'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        en = 1'b0;
        press(3'($urandom));
        en = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 6)) step();
        en = 1'b1;
      end
      step();
    end

    // Asynchronous reset mid-line.
    mode_sel = 2'd1;
    for (int i = 0; i < HT * VT && mx != 30; i++) step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_line");
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    step();
    check("first_fs_after_reset", 64'(frame_start), 64'(1));
    run_frames(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
